// File: rtl/uart_frame_tx.sv
// UART frame transmitter: optional start bit, DATA_W data bits, optional parity, 1-2 stop bits.
// Bits are paced by an external baud strobe; a one-word holding register feeds the shifter.
module uart_frame_tx #(
  parameter int DATA_W    = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int MSB_FIRST = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              en,
  input  logic              bit_tick,
  input  logic              skip_start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              o_bit,
  output logic              busy,
  output logic              bit_useful,
  output logic              frame_done
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_W - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t            state;
  state_t            state_next;
  logic              hold_full;
  logic [DATA_W-1:0] hold_data;
  logic [DATA_W-1:0] shift_reg;
  logic [CNT_W-1:0]  bit_cnt;
  logic              stop_cnt;
  logic              par_bit;
  logic              tick_en;
  logic              launch;
  logic              stop_last;

  assign tick_en   = en && bit_tick;
  assign stop_last = (stop_cnt == STOP_LAST);
  assign in_ready  = !hold_full;

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  // A launch can happen from IDLE or straight out of the last stop bit (back-to-back).
  always_comb begin
    state_next = state;
    launch     = 1'b0;
    frame_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (tick_en && hold_full) launch = 1'b1;
      end
      START: begin
        if (tick_en) state_next = DATA;
      end
      DATA: begin
        if (tick_en && bit_cnt == BIT_LAST) state_next = (PARITY != 0) ? PAR : STOP;
      end
      PAR: begin
        if (tick_en) state_next = STOP;
      end
      STOP: begin
        if (tick_en && stop_last) begin
          frame_done = 1'b1;
          if (hold_full) launch = 1'b1;
          else           state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (launch) state_next = skip_start ? DATA : START;
    if (!en)    state_next = IDLE;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      hold_full <= 1'b0;
      hold_data <= '0;
    end else if (launch) begin
      hold_full <= 1'b0;
    end else if (in_valid && !hold_full) begin
      hold_full <= 1'b1;
      hold_data <= in_data;
    end
  end

  // Parity is frozen from the launched word so the shifting data cannot disturb it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
      par_bit   <= 1'b0;
    end else if (!en) begin
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
    end else if (launch) begin
      shift_reg <= hold_data;
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
      par_bit   <= (^hold_data) ^ (PARITY == 2);
    end else if (tick_en) begin
      case (state)
        DATA: begin
          shift_reg <= (MSB_FIRST != 0) ? {shift_reg[DATA_W-2:0], 1'b0}
                                        : {1'b0, shift_reg[DATA_W-1:1]};
          bit_cnt   <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
        end
        STOP: begin
          stop_cnt <= stop_last ? 1'b0 : stop_cnt + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    o_bit = 1'b1;
    unique case (state)
      IDLE:    o_bit = 1'b1;
      START:   o_bit = 1'b0;
      DATA:    o_bit = (MSB_FIRST != 0) ? shift_reg[DATA_W-1] : shift_reg[0];
      PAR:     o_bit = par_bit;
      STOP:    o_bit = 1'b1;
      default: o_bit = 1'b1;
    endcase
  end

  assign busy       = (state != IDLE);
  assign bit_useful = (state == DATA);

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx: three instances cover the parity / stop / bit-order variants.
module tb_uart_frame_tx;

  logic       CLK;
  logic       RST;
  logic       en;
  logic       bit_tick;
  logic       skip_start;
  logic [7:0] in_data;
  logic       valid_a, valid_b, valid_c;
  logic       in_ready_a, o_bit_a, busy_a, bit_useful_a, frame_done_a;
  logic       in_ready_b, o_bit_b, busy_b, bit_useful_b, frame_done_b;
  logic       in_ready_c, o_bit_c, busy_c, bit_useful_c, frame_done_c;

  int checks   = 0;
  int failures = 0;
  int fd_cnt_a = 0;
  int fd_cnt_b = 0;
  int fd_cnt_c = 0;

  uart_frame_tx #(.DATA_W(8), .PARITY(1), .STOP_BITS(1), .MSB_FIRST(0)) u_a (
    .CLK(CLK), .RST(RST), .en(en), .bit_tick(bit_tick), .skip_start(skip_start),
    .in_data(in_data), .in_valid(valid_a), .in_ready(in_ready_a), .o_bit(o_bit_a),
    .busy(busy_a), .bit_useful(bit_useful_a), .frame_done(frame_done_a));

  uart_frame_tx #(.DATA_W(8), .PARITY(2), .STOP_BITS(2), .MSB_FIRST(1)) u_b (
    .CLK(CLK), .RST(RST), .en(en), .bit_tick(bit_tick), .skip_start(skip_start),
    .in_data(in_data), .in_valid(valid_b), .in_ready(in_ready_b), .o_bit(o_bit_b),
    .busy(busy_b), .bit_useful(bit_useful_b), .frame_done(frame_done_b));

  uart_frame_tx #(.DATA_W(8), .PARITY(0), .STOP_BITS(1), .MSB_FIRST(1)) u_c (
    .CLK(CLK), .RST(RST), .en(en), .bit_tick(bit_tick), .skip_start(skip_start),
    .in_data(in_data), .in_valid(valid_c), .in_ready(in_ready_c), .o_bit(o_bit_c),
    .busy(busy_c), .bit_useful(bit_useful_c), .frame_done(frame_done_c));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // frame_done pulses are tallied mid-cycle so whole-frame pulse counts can be checked.
  always @(negedge CLK) begin
    if (frame_done_a) fd_cnt_a++;
    if (frame_done_b) fd_cnt_b++;
    if (frame_done_c) fd_cnt_c++;
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic load_word(input int which, input logic [7:0] data);
    in_data = data;
    case (which)
      0:       valid_a = 1'b1;
      1:       valid_b = 1'b1;
      default: valid_c = 1'b1;
    endcase
    cyc();
    valid_a = 1'b0;
    valid_b = 1'b0;
    valid_c = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) cyc();
    checks++;
    if ({o_bit_a, busy_a, bit_useful_a, frame_done_a, in_ready_a} !== 5'b10001) begin
      failures++;
      $display("[TB] FAIL reset_a got=%b want=10001",
               {o_bit_a, busy_a, bit_useful_a, frame_done_a, in_ready_a});
    end
    checks++;
    if ({o_bit_b, busy_b, bit_useful_b, frame_done_b, in_ready_b} !== 5'b10001) begin
      failures++;
      $display("[TB] FAIL reset_b got=%b want=10001",
               {o_bit_b, busy_b, bit_useful_b, frame_done_b, in_ready_b});
    end
    checks++;
    if ({o_bit_c, busy_c, bit_useful_c, frame_done_c, in_ready_c} !== 5'b10001) begin
      failures++;
      $display("[TB] FAIL reset_c got=%b want=10001",
               {o_bit_c, busy_c, bit_useful_c, frame_done_c, in_ready_c});
    end
    RST = 1'b0;
    cyc();
  endtask

  task automatic test_even_lsb();
    logic exp_bits [0:10];
    int   fd0;
    exp_bits = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    fd0 = fd_cnt_a;
    load_word(0, 8'hA5);
    checks++;
    if (in_ready_a !== 1'b0) begin
      failures++;
      $display("[TB] FAIL even_ready_after_load got=%b want=0", in_ready_a);
    end
    repeat (3) cyc();
    checks++;
    if ({busy_a, o_bit_a} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL even_no_tick_idle got=%b want=01", {busy_a, o_bit_a});
    end
    for (int i = 0; i < 11; i++) begin
      bit_tick = 1'b1;
      cyc();
      bit_tick = 1'b0;
      for (int c = 0; c < 4; c++) begin
        checks++;
        if (o_bit_a !== exp_bits[i]) begin
          failures++;
          $display("[TB] FAIL even_bit%0d_clk%0d got=%b want=%b", i, c, o_bit_a, exp_bits[i]);
        end
        if (c < 3) cyc();
      end
    end
    bit_tick = 1'b1;
    #1;
    checks++;
    if (frame_done_a !== 1'b1) begin
      failures++;
      $display("[TB] FAIL even_frame_done got=%b want=1", frame_done_a);
    end
    cyc();
    bit_tick = 1'b0;
    checks++;
    if ({busy_a, o_bit_a, frame_done_a, in_ready_a} !== 4'b0101) begin
      failures++;
      $display("[TB] FAIL even_end_idle got=%b want=0101",
               {busy_a, o_bit_a, frame_done_a, in_ready_a});
    end
    checks++;
    if (fd_cnt_a - fd0 !== 1) begin
      failures++;
      $display("[TB] FAIL even_done_count got=%0d want=1", fd_cnt_a - fd0);
    end
  endtask

  task automatic test_odd_two_stop();
    logic exp_bits [0:11];
    int   fd0;
    exp_bits = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    fd0 = fd_cnt_b;
    load_word(1, 8'h01);
    bit_tick = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cyc();
      checks++;
      if (o_bit_b !== exp_bits[i]) begin
        failures++;
        $display("[TB] FAIL odd_bit%0d got=%b want=%b", i, o_bit_b, exp_bits[i]);
      end
      checks++;
      if (bit_useful_b !== (i >= 1 && i <= 8)) begin
        failures++;
        $display("[TB] FAIL odd_useful%0d got=%b want=%b", i, bit_useful_b, (i >= 1 && i <= 8));
      end
    end
    checks++;
    if (frame_done_b !== 1'b1) begin
      failures++;
      $display("[TB] FAIL odd_frame_done got=%b want=1", frame_done_b);
    end
    cyc();
    bit_tick = 1'b0;
    checks++;
    if ({busy_b, o_bit_b} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL odd_end_idle got=%b want=01", {busy_b, o_bit_b});
    end
    checks++;
    if (fd_cnt_b - fd0 !== 1) begin
      failures++;
      $display("[TB] FAIL odd_done_count got=%0d want=1", fd_cnt_b - fd0);
    end
  endtask

  task automatic test_back_to_back();
    int fd0;
    fd0 = fd_cnt_c;
    load_word(2, 8'h00);
    for (int t = 1; t <= 21; t++) begin
      bit_tick = 1'b1;
      #1;
      checks++;
      if (frame_done_c !== (t == 11 || t == 21)) begin
        failures++;
        $display("[TB] FAIL b2b_done_t%0d got=%b want=%b", t, frame_done_c, (t == 11 || t == 21));
      end
      cyc();
      bit_tick = 1'b0;
      checks++;
      if (o_bit_c !== (t == 10 || t >= 12)) begin
        failures++;
        $display("[TB] FAIL b2b_bit_t%0d got=%b want=%b", t, o_bit_c, (t == 10 || t >= 12));
      end
      checks++;
      if (in_ready_c !== (t <= 3 || t >= 11)) begin
        failures++;
        $display("[TB] FAIL b2b_ready_t%0d got=%b want=%b", t, in_ready_c, (t <= 3 || t >= 11));
      end
      if (t == 3) load_word(2, 8'hFF);
      else        cyc();
    end
    checks++;
    if (busy_c !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_end_busy got=%b want=0", busy_c);
    end
    checks++;
    if (fd_cnt_c - fd0 !== 2) begin
      failures++;
      $display("[TB] FAIL b2b_done_count got=%0d want=2", fd_cnt_c - fd0);
    end
  endtask

  task automatic test_skip_start();
    skip_start = 1'b1;
    load_word(2, 8'h80);
    for (int t = 1; t <= 10; t++) begin
      bit_tick = 1'b1;
      #1;
      checks++;
      if (frame_done_c !== (t == 10)) begin
        failures++;
        $display("[TB] FAIL skip_done_t%0d got=%b want=%b", t, frame_done_c, (t == 10));
      end
      cyc();
      bit_tick   = 1'b0;
      skip_start = 1'b0;
      checks++;
      if (o_bit_c !== (t == 1 || t >= 9)) begin
        failures++;
        $display("[TB] FAIL skip_bit_t%0d got=%b want=%b", t, o_bit_c, (t == 1 || t >= 9));
      end
      checks++;
      if (bit_useful_c !== (t <= 8)) begin
        failures++;
        $display("[TB] FAIL skip_useful_t%0d got=%b want=%b", t, bit_useful_c, (t <= 8));
      end
      cyc();
    end
    checks++;
    if (busy_c !== 1'b0) begin
      failures++;
      $display("[TB] FAIL skip_end_busy got=%b want=0", busy_c);
    end
  endtask

  task automatic test_en_drop();
    logic exp_first [1:5];
    logic exp_second [1:11];
    int   fd0;
    exp_first  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_second = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    fd0 = fd_cnt_c;
    load_word(2, 8'h3C);
    for (int t = 1; t <= 5; t++) begin
      bit_tick = 1'b1;
      cyc();
      bit_tick = 1'b0;
      checks++;
      if (o_bit_c !== exp_first[t]) begin
        failures++;
        $display("[TB] FAIL endrop_first_t%0d got=%b want=%b", t, o_bit_c, exp_first[t]);
      end
      if (t == 2) load_word(2, 8'h96);
      else if (t < 5) cyc();
    end
    en = 1'b0;
    cyc();
    checks++;
    if ({o_bit_c, busy_c, bit_useful_c, in_ready_c} !== 4'b1000) begin
      failures++;
      $display("[TB] FAIL endrop_abort got=%b want=1000",
               {o_bit_c, busy_c, bit_useful_c, in_ready_c});
    end
    bit_tick = 1'b1;
    cyc();
    bit_tick = 1'b0;
    cyc();
    checks++;
    if ({busy_c, in_ready_c} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL endrop_tick_ignored got=%b want=00", {busy_c, in_ready_c});
    end
    checks++;
    if (fd_cnt_c - fd0 !== 0) begin
      failures++;
      $display("[TB] FAIL endrop_no_done got=%0d want=0", fd_cnt_c - fd0);
    end
    en = 1'b1;
    cyc();
    checks++;
    if (busy_c !== 1'b0) begin
      failures++;
      $display("[TB] FAIL endrop_wait_tick got=%b want=0", busy_c);
    end
    for (int t = 1; t <= 11; t++) begin
      bit_tick = 1'b1;
      #1;
      checks++;
      if (frame_done_c !== (t == 11)) begin
        failures++;
        $display("[TB] FAIL endrop_done_t%0d got=%b want=%b", t, frame_done_c, (t == 11));
      end
      cyc();
      bit_tick = 1'b0;
      checks++;
      if (o_bit_c !== exp_second[t]) begin
        failures++;
        $display("[TB] FAIL endrop_second_t%0d got=%b want=%b", t, o_bit_c, exp_second[t]);
      end
      checks++;
      if (in_ready_c !== 1'b1) begin
        failures++;
        $display("[TB] FAIL endrop_ready_t%0d got=%b want=1", t, in_ready_c);
      end
      cyc();
    end
    checks++;
    if (fd_cnt_c - fd0 !== 1) begin
      failures++;
      $display("[TB] FAIL endrop_done_count got=%0d want=1", fd_cnt_c - fd0);
    end
  endtask

  task automatic test_reset_mid();
    load_word(2, 8'h55);
    for (int t = 1; t <= 3; t++) begin
      bit_tick = 1'b1;
      cyc();
      bit_tick = 1'b0;
      if (t == 2) load_word(2, 8'hAA);
    end
    checks++;
    if ({busy_c, in_ready_c} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL rstmid_pre got=%b want=10", {busy_c, in_ready_c});
    end
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    checks++;
    if ({o_bit_c, busy_c, bit_useful_c, frame_done_c, in_ready_c} !== 5'b10001) begin
      failures++;
      $display("[TB] FAIL rstmid_outputs got=%b want=10001",
               {o_bit_c, busy_c, bit_useful_c, frame_done_c, in_ready_c});
    end
    for (int t = 1; t <= 3; t++) begin
      bit_tick = 1'b1;
      cyc();
      bit_tick = 1'b0;
      checks++;
      if ({busy_c, o_bit_c} !== 2'b01) begin
        failures++;
        $display("[TB] FAIL rstmid_discard_t%0d got=%b want=01", t, {busy_c, o_bit_c});
      end
      cyc();
    end
  endtask

  initial begin
    RST        = 1'b1;
    en         = 1'b1;
    bit_tick   = 1'b0;
    skip_start = 1'b0;
    in_data    = 8'h00;
    valid_a    = 1'b0;
    valid_b    = 1'b0;
    valid_c    = 1'b0;
    test_reset();
    test_even_lsb();
    test_odd_two_stop();
    test_back_to_back();
    test_skip_start();
    test_en_drop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_frame_tx.md
# uart_frame_tx

Parametrised UART frame transmitter. It serialises one data word per frame: optional start bit, DATA_W data bits in a selectable bit order, optional even/odd parity, and 1 or 2 stop bits. Bit periods are paced by an external baud strobe rather than one bit per clock. A one-word holding register decouples the upstream valid/ready source from the line. The block sits between the byte/word producer and the TX pin in the UART path.

## Interface
- DATA_W, 8: data bits per frame, 5..16
- PARITY, 0: 0 none, 1 even, 2 odd
- STOP_BITS, 1: stop bits per frame, 1 or 2
- MSB_FIRST, 1: 1 sends data MSB first, 0 sends LSB first
- CLK  in  1  system clock; all logic on the rising edge
- RST  in  1  reset, synchronous, active-high
- en  in  1  transmitter enable; low aborts any frame and forces the line idle
- bit_tick  in  1  baud strobe; one bit period = interval between ticks
- skip_start  in  1  sampled at frame launch; 1 = frame has no start bit
- in_data  in  DATA_W  word to send
- in_valid  in  1  in_data valid
- in_ready  out  1  holding register empty; word accepted on in_valid && in_ready
- o_bit  out  1  serial line, idle high
- busy  out  1  frame in progress (state != IDLE)
- bit_useful  out  1  o_bit currently carries a data bit (state == DATA)
- frame_done  out  1  one-cycle pulse at completion of the final stop bit

## Operation
- States: IDLE, START, DATA, PAR, STOP. `tick_en = en && bit_tick`.
- Holding register:
  - Loaded when in_valid && in_ready.
  - in_ready = !hold_full, independent of en and bit_tick.
  - Cleared when its word is launched.
- Launch:
  - Occurs on a tick_en cycle with hold_full, in IDLE or on the last STOP bit.
  - Shift register <= hold word; bit counter <= 0.
  - skip_start latched: next state DATA if set, else START.
- Transitions (only on tick_en cycles):
  - START -> DATA.
  - DATA -> DATA until bit counter == DATA_W-1, then PAR if PARITY != 0, else STOP.
  - PAR -> STOP.
  - STOP: on its last bit (stop counter == STOP_BITS-1), launch if hold_full, else go to IDLE.
- o_bit by state:
  - IDLE 1, START 0.
  - DATA: shift-register MSB (MSB_FIRST=1) or LSB (MSB_FIRST=0); shift one position per tick in DATA.
  - PAR: XOR of the launched word for even parity, its inverse for odd parity.
  - STOP 1.
- Parity is computed from the word captured at launch, not from the shift register.
- o_bit, busy and bit_useful depend only on registered state (no input-to-output combinational path).
- en low:
  - Next clock: state IDLE, counters 0, o_bit 1, busy 0.
  - No frame_done pulse.
  - Holding register and in_ready are unaffected.
  - When en returns, any held word launches on the next tick.
- Frame length: (skip_start ? 0 : 1) + DATA_W + (PARITY != 0) + STOP_BITS bit periods.

## Timing
- Reset values: state IDLE, hold_full 0, counters 0, in_ready 1, o_bit 1, busy 0, bit_useful 0, frame_done 0.
- in_ready falls the cycle after acceptance and rises the cycle after launch.
- Launch latency: the word goes onto the line at the edge ending the first tick_en cycle after the word is held, and no earlier.
- Each bit is held from one tick edge to the next.
- frame_done is asserted during the tick_en cycle that ends the last stop bit; it is high for exactly one cycle.
- Back-to-back: if hold_full on the final stop tick, the next start (or data) bit follows immediately, with no idle bit.
- bit_tick asserted on consecutive cycles is legal: one bit per clock.
- bit_tick while en=0 is ignored.
- in_valid && in_ready on the same cycle as a launch from an empty register cannot occur, since in_ready=1 implies no word is held.

## Test plan
- PARITY=1, STOP_BITS=1, MSB_FIRST=0, tick every 4 clocks, send 0xA5:
  - o_bit = 0,1,0,1,0,0,1,0,1,0,1, each held 4 clocks.
  - frame_done pulses once; busy falls at the same edge.
- PARITY=2, STOP_BITS=2, MSB_FIRST=1, send 0x01:
  - o_bit = 0,0,0,0,0,0,0,0,1,0,1,1.
- Back-to-back 0x00 then 0xFF, second word presented while the first frame is in DATA:
  - in_ready low until the second launch.
  - Stop bit of 0x00 is followed directly by the start bit of 0xFF.
  - Two frame_done pulses, 10 ticks apart (PARITY=0).
- skip_start=1, send 0x80, MSB_FIRST=1, PARITY=0:
  - o_bit = 1,0,0,0,0,0,0,0,1; frame length 9 ticks.
- en dropped during the 4th data bit, with a second word held:
  - o_bit = 1 and busy = 0 on the next clock; no frame_done.
  - in_ready stays 0.
  - After en returns, the held word is transmitted as a full frame from the next tick.
- RST asserted mid-frame, with a word held:
  - All outputs return to reset values on the next clock.
  - The held word is discarded.
  - in_ready = 1.
